// File: rtl/pipe_ctrl.sv
// Pipeline hold/flush controller: merges stall and redirect requests into one hold level,
// stretches redirects into a flush window and sequences debug halt. Perf counters under PIPE_CTRL_PERF_EN.
module pipe_ctrl #(
  parameter int FLUSH_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        jump_flag_i,
  input  logic [31:0] jump_addr_i,
  input  logic        int_assert_i,
  input  logic [31:0] int_addr_i,
  input  logic        hold_ex_i,
  input  logic        hold_bus_i,
  input  logic        jtag_halt_i,
  output logic [2:0]  hold_flag_o,
  output logic        jump_flag_o,
  output logic [31:0] jump_addr_o,
  output logic        halted_o,
  output logic [31:0] stall_cnt_o,
  output logic [31:0] flush_cnt_o
);

  localparam logic [2:0] HOLD_NONE = 3'd0;
  localparam logic [2:0] HOLD_PC   = 3'd1;
  localparam logic [2:0] HOLD_ID   = 3'd3;
  localparam bit         FLUSH_EN  = (FLUSH_CYCLES > 0);
  localparam int         LOAD_INT  = FLUSH_EN ? FLUSH_CYCLES - 1 : 0;
  localparam logic [2:0] FLUSH_LOAD = LOAD_INT[2:0];

  typedef enum logic [1:0] {RUN, FLUSH, HALT} state_t;

  state_t     state, state_nxt;
  logic [2:0] flush_cnt_r, flush_cnt_nxt;
  logic       redir;

  assign redir = int_assert_i | jump_flag_i;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= RUN;
      flush_cnt_r <= 3'd0;
      halted_o    <= 1'b0;
    end else begin
      state       <= state_nxt;
      flush_cnt_r <= flush_cnt_nxt;
      halted_o    <= (state_nxt == HALT);
    end
  end

  // Halt is never entered while a multi-cycle execute op is in flight.
  always_comb begin
    state_nxt     = state;
    flush_cnt_nxt = flush_cnt_r;
    jump_flag_o   = redir;
    jump_addr_o   = int_assert_i ? int_addr_i : (jump_flag_i ? jump_addr_i : 32'd0);
    if (redir || state == FLUSH || hold_ex_i)
      hold_flag_o = HOLD_ID;
    else if (hold_bus_i || state == HALT || jtag_halt_i)
      hold_flag_o = HOLD_PC;
    else
      hold_flag_o = HOLD_NONE;

    if (redir && FLUSH_EN) begin
      state_nxt     = FLUSH;
      flush_cnt_nxt = FLUSH_LOAD;
    end else begin
      case (state)
        RUN:   if (jtag_halt_i && !hold_ex_i) state_nxt = HALT;
        FLUSH: begin
          if (flush_cnt_r == 3'd0)
            state_nxt = (jtag_halt_i && !hold_ex_i) ? HALT : RUN;
          else
            flush_cnt_nxt = flush_cnt_r - 3'd1;
        end
        HALT:  if (!jtag_halt_i) state_nxt = RUN;
        default: state_nxt = RUN;
      endcase
    end
  end

`ifdef PIPE_CTRL_PERF_EN
  logic [31:0] stall_cnt_r, perf_flush_r;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt_r  <= 32'd0;
      perf_flush_r <= 32'd0;
    end else begin
      if (hold_flag_o != HOLD_NONE && stall_cnt_r != 32'hFFFF_FFFF)
        stall_cnt_r <= stall_cnt_r + 32'd1;
      if (redir && perf_flush_r != 32'hFFFF_FFFF)
        perf_flush_r <= perf_flush_r + 32'd1;
    end
  end

  assign stall_cnt_o = stall_cnt_r;
  assign flush_cnt_o = perf_flush_r;
`else
  assign stall_cnt_o = 32'd0;
  assign flush_cnt_o = 32'd0;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl: FLUSH_CYCLES=1 main instance plus a FLUSH_CYCLES=0 instance.
module tb_pipe_ctrl;
  logic        clk = 1'b0;
  logic        rst;
  logic        jump_flag_i, int_assert_i, hold_ex_i, hold_bus_i, jtag_halt_i;
  logic [31:0] jump_addr_i, int_addr_i;
  logic [2:0]  hold_flag_o, hold0;
  logic        jump_flag_o, halted_o, jf0, halted0;
  logic [31:0] jump_addr_o, stall_cnt_o, flush_cnt_o, ja0, sc0, fc0;

  int n_total = 0;
  int n_pass  = 0;

  always #5 clk = ~clk;

  pipe_ctrl #(.FLUSH_CYCLES(1)) dut (
    .clk(clk), .rst(rst), .jump_flag_i(jump_flag_i), .jump_addr_i(jump_addr_i),
    .int_assert_i(int_assert_i), .int_addr_i(int_addr_i), .hold_ex_i(hold_ex_i),
    .hold_bus_i(hold_bus_i), .jtag_halt_i(jtag_halt_i), .hold_flag_o(hold_flag_o),
    .jump_flag_o(jump_flag_o), .jump_addr_o(jump_addr_o), .halted_o(halted_o),
    .stall_cnt_o(stall_cnt_o), .flush_cnt_o(flush_cnt_o));

  pipe_ctrl #(.FLUSH_CYCLES(0)) dut0 (
    .clk(clk), .rst(rst), .jump_flag_i(jump_flag_i), .jump_addr_i(jump_addr_i),
    .int_assert_i(int_assert_i), .int_addr_i(int_addr_i), .hold_ex_i(hold_ex_i),
    .hold_bus_i(hold_bus_i), .jtag_halt_i(jtag_halt_i), .hold_flag_o(hold0),
    .jump_flag_o(jf0), .jump_addr_o(ja0), .halted_o(halted0),
    .stall_cnt_o(sc0), .flush_cnt_o(fc0));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Inputs change 1 time unit after a rising edge; checks follow 1 unit later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr();
    jump_flag_i = 0; jump_addr_i = 0; int_assert_i = 0; int_addr_i = 0;
    hold_ex_i = 0; hold_bus_i = 0; jtag_halt_i = 0;
  endtask

  initial begin
    rst = 1'b1;
    clr();
    #1;
    check("rst_hold", hold_flag_o, 0);
    check("rst_jf", jump_flag_o, 0);
    check("rst_ja", jump_addr_o, 0);
    check("rst_halted", halted_o, 0);
    check("rst_stall", stall_cnt_o, 0);
    check("rst_flush", flush_cnt_o, 0);
    tick();
    rst = 1'b0;
    tick();

    // Isolated jump: two Hold_Id cycles (one with FLUSH_CYCLES=0)
    jump_flag_i = 1; jump_addr_i = 32'h100;
    #1;
    check("jmp_jf", jump_flag_o, 1);
    check("jmp_ja", jump_addr_o, 32'h100);
    check("jmp_hold0", hold_flag_o, 3);
    check("jmp_fc0_hold0", hold0, 3);
    tick(); clr(); #1;
    check("jmp_hold1", hold_flag_o, 3);
    check("jmp_jf_off", jump_flag_o, 0);
    check("jmp_ja_off", jump_addr_o, 0);
    check("jmp_fc0_hold1", hold0, 0);
    tick(); #1;
    check("jmp_hold2", hold_flag_o, 0);
`ifdef PIPE_CTRL_PERF_EN
    check("jmp_stall", stall_cnt_o, 2);
    check("jmp_flush", flush_cnt_o, 1);
`else
    check("jmp_stall_off", stall_cnt_o, 0);
    check("jmp_flush_off", flush_cnt_o, 0);
`endif
    tick();

    // Simultaneous interrupt + jump: interrupt target wins
    int_assert_i = 1; int_addr_i = 32'h8; jump_flag_i = 1; jump_addr_i = 32'h100;
    #1;
    check("sim_ja", jump_addr_o, 32'h8);
    check("sim_jf", jump_flag_o, 1);
    check("sim_hold", hold_flag_o, 3);
    tick(); clr(); #1;
    check("sim_flush_win", hold_flag_o, 3);
`ifdef PIPE_CTRL_PERF_EN
    check("sim_flush_cnt", flush_cnt_o, 2);
`endif
    tick(); #1;
    check("sim_end", hold_flag_o, 0);

    // Execute stall overlapping bus hold
    for (int i = 0; i < 7; i++) begin
      tick();
      hold_ex_i  = (i < 4);
      hold_bus_i = (i >= 2 && i < 6);
      #1;
      check($sformatf("exbus_%0d", i), hold_flag_o, (i < 4) ? 3 : ((i < 6) ? 1 : 0));
    end
`ifdef PIPE_CTRL_PERF_EN
    check("exbus_stall", stall_cnt_o, 10);
`endif

    // Halt requested during a divide: deferred until hold_ex_i drops
    for (int i = 0; i < 3; i++) begin
      tick();
      hold_ex_i = 1; jtag_halt_i = 1;
      #1;
      check($sformatf("defer_hold_%0d", i), hold_flag_o, 3);
      check($sformatf("defer_halted_%0d", i), halted_o, 0);
    end
    tick(); hold_ex_i = 0; #1;
    check("defer_drop_hold", hold_flag_o, 1);
    check("defer_drop_halted", halted_o, 0);
    tick(); #1;
    check("halted_rise", halted_o, 1);
    check("halted_hold", hold_flag_o, 1);

    // Interrupt while halted: flush, then back to halt
    tick(); int_assert_i = 1; int_addr_i = 32'h8; #1;
    check("hint_hold", hold_flag_o, 3);
    check("hint_ja", jump_addr_o, 32'h8);
    tick(); int_assert_i = 0; int_addr_i = 0; #1;
    check("hint_flush_hold", hold_flag_o, 3);
    check("hint_flush_halted", halted_o, 0);
    tick(); #1;
    check("hint_rehalt", halted_o, 1);
    check("hint_rehalt_hold", hold_flag_o, 1);
    tick(); jtag_halt_i = 0; #1;
    check("unhalt_hold", hold_flag_o, 1);
    check("unhalt_halted", halted_o, 1);
    tick(); #1;
    check("run_halted", halted_o, 0);
    check("run_hold", hold_flag_o, 0);
`ifdef PIPE_CTRL_PERF_EN
    check("halt_stall", stall_cnt_o, 19);
    check("halt_flush", flush_cnt_o, 3);
`endif

    // Back-to-back jump restarts the flush window
    tick(); jump_flag_i = 1; jump_addr_i = 32'h200; #1;
    check("b2b_h0", hold_flag_o, 3);
    tick(); jump_addr_i = 32'h300; #1;
    check("b2b_h1", hold_flag_o, 3);
    check("b2b_ja", jump_addr_o, 32'h300);
    tick(); clr(); #1;
    check("b2b_h2", hold_flag_o, 3);
    tick(); #1;
    check("b2b_h3", hold_flag_o, 0);
`ifdef PIPE_CTRL_PERF_EN
    check("b2b_stall", stall_cnt_o, 22);
    check("b2b_flush", flush_cnt_o, 5);
`endif

    // Asynchronous reset in the middle of a flush window
    tick(); jump_flag_i = 1; jump_addr_i = 32'h40;
    tick(); clr(); #1;
    check("rstf_pre", hold_flag_o, 3);
    rst = 1'b1; #1;
    check("rstf_hold", hold_flag_o, 0);
    check("rstf_stall", stall_cnt_o, 0);
    check("rstf_flush", flush_cnt_o, 0);
    tick(); rst = 1'b0;
    tick(); #1;
    check("rstf_noreplay", hold_flag_o, 0);

    // Asynchronous reset while halted
    tick(); jtag_halt_i = 1;
    tick(); #1;
    check("rsth_pre", halted_o, 1);
    jtag_halt_i = 0; rst = 1'b1; #1;
    check("rsth_halted", halted_o, 0);
    check("rsth_hold", hold_flag_o, 0);
    tick(); rst = 1'b0;
    tick(); #1;
    check("rsth_after", hold_flag_o, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end
endmodule
